// File: rtl/reorder_buffer.sv
// 16-entry circular reorder buffer: allocates tags at dispatch, captures CDB results,
// answers operand-readiness queries and retires in order, flushing on a mispredicted branch.
module reorder_buffer #(
    parameter int DEPTH = 16,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             dispatch_valid,
    input  logic [4:0]       dispatch_rd,
    input  logic             dispatch_is_branch,
    output logic [TAG_W-1:0] dispatch_tag,
    output logic             full,
    input  logic [TAG_W-1:0] query_tag1,
    input  logic [TAG_W-1:0] query_tag2,
    output logic             query_ready1,
    output logic             query_ready2,
    output logic [31:0]      query_data1,
    output logic [31:0]      query_data2,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_data,
    input  logic             cdb_mispredict,
    input  logic [31:0]      cdb_target_pc,
    output logic             if_commit,
    output logic [4:0]       pos_commit,
    output logic [31:0]      data_commit,
    output logic [TAG_W-1:0] tag_commit,
    output logic             clear,
    output logic [31:0]      clear_pc
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [TAG_W-1:0] EMPTY_TAG  = TAG_W'(DEPTH);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(DEPTH);

    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] ready;
    logic [DEPTH-1:0] is_branch;
    logic [DEPTH-1:0] mispredict;
    logic [4:0]       rd_q     [DEPTH];
    logic [31:0]      data_q   [DEPTH];
    logic [31:0]      target_q [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] cdb_idx;
    logic [PTR_W:0]   count;

    logic do_dispatch;
    logic cdb_hit;
    logic do_retire;
    logic do_flush;
    logic do_commit;

    assign cdb_idx      = cdb_tag[PTR_W-1:0];
    assign full         = (count == FULL_COUNT);
    assign dispatch_tag = TAG_W'(tail);

    // Flush only acts on branches; a stray mispredict flag on any other entry is ignored.
    assign do_dispatch = dispatch_valid && !full && !clear;
    assign cdb_hit     = cdb_valid && !clear && (cdb_tag < EMPTY_TAG) && busy[cdb_idx];
    assign do_retire   = busy[head] && ready[head];
    assign do_flush    = do_retire && is_branch[head] && mispredict[head];
    assign do_commit   = do_retire && (rd_q[head] != 5'd0);

    function automatic logic [32:0] lookup(input logic [TAG_W-1:0] t);
        logic [PTR_W-1:0] idx;
        idx = t[PTR_W-1:0];
        if (t >= EMPTY_TAG)
            return '0;
        if (cdb_valid && cdb_tag == t)
            return {1'b1, cdb_data};
        return {ready[idx], data_q[idx]};
    endfunction

    always_comb begin
        {query_ready1, query_data1} = lookup(query_tag1);
        {query_ready2, query_data2} = lookup(query_tag2);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy        <= '0;
            ready       <= '0;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            if_commit   <= 1'b0;
            pos_commit  <= '0;
            data_commit <= '0;
            tag_commit  <= EMPTY_TAG;
            clear       <= 1'b0;
            clear_pc    <= '0;
        end else if (rdy) begin
            if_commit <= do_commit;
            if (do_commit) begin
                pos_commit  <= rd_q[head];
                data_commit <= data_q[head];
                tag_commit  <= TAG_W'(head);
            end
            clear    <= do_flush;
            clear_pc <= do_flush ? target_q[head] : 32'd0;

            if (do_flush) begin
                busy  <= '0;
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (cdb_hit)
                    ready[cdb_idx] <= 1'b1;
                if (do_retire) begin
                    busy[head] <= 1'b0;
                    head       <= head + 1'b1;
                end
                if (do_dispatch) begin
                    busy[tail]  <= 1'b1;
                    ready[tail] <= 1'b0;
                    tail        <= tail + 1'b1;
                end
                if (do_dispatch && !do_retire)
                    count <= count + 1'b1;
                else if (!do_dispatch && do_retire)
                    count <= count - 1'b1;
            end
        end
    end

    // Payload fields are only meaningful while busy/ready, so they carry no reset.
    always_ff @(posedge clk) begin
        if (rdy) begin
            if (do_dispatch) begin
                rd_q[tail]      <= dispatch_rd;
                is_branch[tail] <= dispatch_is_branch;
            end
            if (cdb_hit) begin
                data_q[cdb_idx]     <= cdb_data;
                mispredict[cdb_idx] <= cdb_mispredict;
                target_q[cdb_idx]   <= cdb_target_pc;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a queue-based behavioural model.
module tb_reorder_buffer;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        dispatch_valid, dispatch_is_branch;
    logic [4:0]  dispatch_rd, dispatch_tag;
    logic        full;
    logic [4:0]  query_tag1, query_tag2;
    logic        query_ready1, query_ready2;
    logic [31:0] query_data1, query_data2;
    logic        cdb_valid, cdb_mispredict;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_data, cdb_target_pc;
    logic        if_commit, clear;
    logic [4:0]  pos_commit, tag_commit;
    logic [31:0] data_commit, clear_pc;

    int checks = 0;
    int errors = 0;

    reorder_buffer #(.DEPTH(DEPTH), .TAG_W(5)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .dispatch_valid(dispatch_valid), .dispatch_rd(dispatch_rd),
        .dispatch_is_branch(dispatch_is_branch), .dispatch_tag(dispatch_tag), .full(full),
        .query_tag1(query_tag1), .query_tag2(query_tag2),
        .query_ready1(query_ready1), .query_ready2(query_ready2),
        .query_data1(query_data1), .query_data2(query_data2),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .cdb_mispredict(cdb_mispredict), .cdb_target_pc(cdb_target_pc),
        .if_commit(if_commit), .pos_commit(pos_commit), .data_commit(data_commit),
        .tag_commit(tag_commit), .clear(clear), .clear_pc(clear_pc)
    );

    always #5 clk = ~clk;

    // Model: program-ordered list of in-flight tags plus per-tag payload.
    int          order[$];
    logic [4:0]  m_rd   [DEPTH];
    bit          m_br   [DEPTH];
    bit          m_ready[DEPTH];
    logic [31:0] m_data [DEPTH];
    bit          m_mis  [DEPTH];
    logic [31:0] m_tpc  [DEPTH];
    int          next_tag = 0;
    bit          model_on = 0;
    bit          e_if_commit, e_clear;
    logic [4:0]  e_pos, e_tag;
    logic [31:0] e_data, e_clear_pc;

    function automatic bit in_flight(input int t);
        foreach (order[i])
            if (order[i] == t)
                return 1'b1;
        return 1'b0;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(posedge clk) begin : model
        bit retire, flush, disp;
        int h;
        if (!rst) begin
            order.delete();
            next_tag    = 0;
            e_if_commit = 0;
            e_pos       = 0;
            e_data      = 0;
            e_tag       = 5'd16;
            e_clear     = 0;
            e_clear_pc  = 0;
            model_on    = 1;
        end else if (rdy && model_on) begin
            retire = (order.size() > 0) && m_ready[order[0]];
            h      = retire ? order[0] : 0;
            flush  = retire && m_br[h] && m_mis[h];
            disp   = dispatch_valid && (order.size() < DEPTH) && !e_clear;
            if (retire && m_rd[h] != 5'd0) begin
                e_if_commit = 1;
                e_pos       = m_rd[h];
                e_data      = m_data[h];
                e_tag       = 5'(h);
            end else begin
                e_if_commit = 0;
            end
            e_clear_pc = flush ? m_tpc[h] : 32'd0;
            if (cdb_valid && !e_clear && cdb_tag < 16 && in_flight(int'(cdb_tag))) begin
                m_ready[cdb_tag] = 1;
                m_data[cdb_tag]  = cdb_data;
                m_mis[cdb_tag]   = cdb_mispredict;
                m_tpc[cdb_tag]   = cdb_target_pc;
            end
            if (flush) begin
                order.delete();
                next_tag = 0;
            end else begin
                if (retire)
                    void'(order.pop_front());
                if (disp) begin
                    order.push_back(next_tag);
                    m_rd[next_tag]    = dispatch_rd;
                    m_br[next_tag]    = dispatch_is_branch;
                    m_ready[next_tag] = 0;
                    next_tag = (next_tag + 1) % DEPTH;
                end
            end
            e_clear = flush;
        end
    end

    task automatic checkQuery(input string name, input logic [4:0] t, input logic r, input logic [31:0] d);
        if (t >= 5'd16) begin
            checkOutput({name, "_ready_empty"}, 32'(r), 32'd0);
            checkOutput({name, "_data_empty"}, d, 32'd0);
        end else if (cdb_valid && cdb_tag == t) begin
            checkOutput({name, "_ready_bypass"}, 32'(r), 32'd1);
            checkOutput({name, "_data_bypass"}, d, cdb_data);
        end else if (in_flight(int'(t))) begin
            checkOutput({name, "_ready"}, 32'(r), 32'(m_ready[t]));
            if (m_ready[t])
                checkOutput({name, "_data"}, d, m_data[t]);
        end
    endtask

    always @(negedge clk) begin
        if (model_on) begin
            checkOutput("if_commit", 32'(if_commit), 32'(e_if_commit));
            checkOutput("pos_commit", 32'(pos_commit), 32'(e_pos));
            checkOutput("data_commit", data_commit, e_data);
            checkOutput("tag_commit", 32'(tag_commit), 32'(e_tag));
            checkOutput("clear", 32'(clear), 32'(e_clear));
            checkOutput("clear_pc", clear_pc, e_clear_pc);
            checkOutput("full", 32'(full), 32'(order.size() == DEPTH));
            checkOutput("dispatch_tag", 32'(dispatch_tag), 32'(next_tag));
            checkQuery("query1", query_tag1, query_ready1, query_data1);
            checkQuery("query2", query_tag2, query_ready2, query_data2);
        end
    end

    task automatic applyStimulus(input bit dv, input logic [4:0] drd, input bit dbr,
                                 input bit cv, input logic [4:0] ct, input logic [31:0] cd,
                                 input bit cm, input logic [31:0] cpc);
        dispatch_valid     = dv;
        dispatch_rd        = drd;
        dispatch_is_branch = dbr;
        cdb_valid          = cv;
        cdb_tag            = ct;
        cdb_data           = cd;
        cdb_mispredict     = cm;
        cdb_target_pc      = cpc;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic doReset();
        rst = 0;
        idle(1);
        rst = 1;
    endtask

    initial begin
        rst = 0; rdy = 1;
        query_tag1 = 5'd16; query_tag2 = 5'd16;
        dispatch_valid = 0; dispatch_rd = 0; dispatch_is_branch = 0;
        cdb_valid = 0; cdb_tag = 0; cdb_data = 0; cdb_mispredict = 0; cdb_target_pc = 0;
        idle(2);
        rst = 1;
        checkOutput("rst_if_commit", 32'(if_commit), 32'd0);
        checkOutput("rst_tag_commit", 32'(tag_commit), 32'd16);
        checkOutput("rst_full", 32'(full), 32'd0);
        checkOutput("rst_dispatch_tag", 32'(dispatch_tag), 32'd0);
        checkOutput("rst_clear_pc", clear_pc, 32'd0);

        // Single instruction: dispatch, CDB, retire two edges after the write.
        applyStimulus(1, 5'd5, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 5'd0, 32'h1234, 0, 0);
        checkOutput("t1_not_yet", 32'(if_commit), 32'd0);
        idle(1);
        checkOutput("t1_if_commit", 32'(if_commit), 32'd1);
        checkOutput("t1_pos", 32'(pos_commit), 32'd5);
        checkOutput("t1_data", data_commit, 32'h1234);
        checkOutput("t1_tag", 32'(tag_commit), 32'd0);
        idle(1);
        checkOutput("t1_pulse_end", 32'(if_commit), 32'd0);

        // Fill, overflow attempt, out-of-order completion, in-order retire.
        doReset();
        for (int i = 0; i < 16; i++)
            applyStimulus(1, 5'(i + 1), 0, 0, 0, 0, 0, 0);
        checkOutput("t2_full", 32'(full), 32'd1);
        checkOutput("t2_tag_wrap", 32'(dispatch_tag), 32'd0);
        applyStimulus(1, 5'd9, 0, 0, 0, 0, 0, 0);
        checkOutput("t2_full_after_17th", 32'(full), 32'd1);
        checkOutput("t2_tag_after_17th", 32'(dispatch_tag), 32'd0);
        for (int t = 15; t >= 0; t--)
            applyStimulus(0, 0, 0, 1, 5'(t), 32'h1000 + 32'(t), 0, 0);
        for (int i = 0; i < 16; i++) begin
            idle(1);
            checkOutput("t2_commit", 32'(if_commit), 32'd1);
            checkOutput("t2_commit_tag", 32'(tag_commit), 32'(i));
            checkOutput("t2_commit_pos", 32'(pos_commit), 32'(i + 1));
            checkOutput("t2_commit_data", data_commit, 32'h1000 + 32'(i));
        end
        idle(1);
        checkOutput("t2_drained_commit", 32'(if_commit), 32'd0);
        checkOutput("t2_drained_full", 32'(full), 32'd0);

        // Same-cycle CDB bypass on a query, then the stored value.
        doReset();
        for (int i = 0; i < 4; i++)
            applyStimulus(1, 5'(i + 1), 0, 0, 0, 0, 0, 0);
        cdb_valid = 1; cdb_tag = 5'd3; cdb_data = 32'hAB;
        query_tag1 = 5'd3; query_tag2 = 5'd16;
        #1;
        checkOutput("t3_bypass_ready", 32'(query_ready1), 32'd1);
        checkOutput("t3_bypass_data", query_data1, 32'hAB);
        checkOutput("t3_empty_ready", 32'(query_ready2), 32'd0);
        @(posedge clk);
        #2;
        cdb_valid = 0; query_tag2 = 5'd2;
        #1;
        checkOutput("t3_stored_ready", 32'(query_ready1), 32'd1);
        checkOutput("t3_stored_data", query_data1, 32'hAB);
        checkOutput("t3_pending_ready", 32'(query_ready2), 32'd0);
        query_tag1 = 5'd16; query_tag2 = 5'd16;

        // Mispredicted branch at head with three completed younger entries.
        doReset();
        applyStimulus(1, 5'd0, 1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 3; i++)
            applyStimulus(1, 5'(i), 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 3; i++)
            applyStimulus(0, 0, 0, 1, 5'(i), 32'h50 + 32'(i), 0, 0);
        applyStimulus(0, 0, 0, 1, 5'd0, 32'd0, 1, 32'h100);
        idle(1);
        checkOutput("t4_clear", 32'(clear), 32'd1);
        checkOutput("t4_clear_pc", clear_pc, 32'h100);
        checkOutput("t4_full", 32'(full), 32'd0);
        checkOutput("t4_dispatch_tag", 32'(dispatch_tag), 32'd0);
        checkOutput("t4_no_commit", 32'(if_commit), 32'd0);
        applyStimulus(1, 5'd4, 0, 1, 5'd1, 32'h99, 0, 0);
        checkOutput("t4_clear_end", 32'(clear), 32'd0);
        checkOutput("t4_clear_pc_end", clear_pc, 32'd0);
        checkOutput("t4_dispatch_ignored", 32'(dispatch_tag), 32'd0);
        repeat (3) begin
            idle(1);
            checkOutput("t4_younger_silent", 32'(if_commit), 32'd0);
        end

        // Reset mid-stream, then a ready head held by rdy=0.
        doReset();
        for (int i = 0; i < 5; i++)
            applyStimulus(1, 5'(i + 1), 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 5'd0, 32'h77, 0, 0);
        rst = 0;
        applyStimulus(1, 5'd6, 0, 0, 0, 0, 0, 0);
        rst = 1;
        checkOutput("t5_rst_commit", 32'(if_commit), 32'd0);
        checkOutput("t5_rst_tag", 32'(tag_commit), 32'd16);
        checkOutput("t5_rst_dtag", 32'(dispatch_tag), 32'd0);
        checkOutput("t5_rst_full", 32'(full), 32'd0);
        applyStimulus(1, 5'd7, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 5'd0, 32'h55, 0, 0);
        rdy = 0;
        repeat (3) begin
            applyStimulus(1, 5'd8, 0, 0, 0, 0, 0, 0);
            checkOutput("t5_frozen_commit", 32'(if_commit), 32'd0);
            checkOutput("t5_frozen_dtag", 32'(dispatch_tag), 32'd1);
        end
        rdy = 1;
        idle(1);
        checkOutput("t5_commit", 32'(if_commit), 32'd1);
        checkOutput("t5_pos", 32'(pos_commit), 32'd7);
        checkOutput("t5_data", data_commit, 32'h55);

        // Randomized traffic against the model.
        doReset();
        repeat (3000) begin
            bit          dv, dbr, cv, cm;
            logic [4:0]  drd, ct;
            rst = ($urandom_range(0, 299) != 0);
            rdy = ($urandom_range(0, 9) != 0);
            dv  = ($urandom_range(0, 1) == 1);
            drd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            dbr = ($urandom_range(0, 3) == 0);
            cv  = ($urandom_range(0, 2) != 0);
            cm  = ($urandom_range(0, 4) == 0);
            if (order.size() > 0 && $urandom_range(0, 3) != 0)
                ct = 5'(order[$urandom_range(0, order.size() - 1)]);
            else
                ct = 5'($urandom_range(0, 16));
            if (order.size() > 0 && $urandom_range(0, 1) == 1)
                query_tag1 = 5'(order[$urandom_range(0, order.size() - 1)]);
            else
                query_tag1 = 5'($urandom_range(0, 16));
            query_tag2 = ($urandom_range(0, 2) == 0) ? ct : 5'($urandom_range(0, 16));
            applyStimulus(dv, drd, dbr, cv, ct, $urandom, cm, $urandom);
        end
        rst = 1; rdy = 1;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Circular 16-entry reorder buffer sitting between the decoder/dispatch stage and the register file. It allocates a tag per dispatched instruction, collects results from the common data bus (CDB) and answers operand-readiness queries from the decoder. It retires in order into the register file's commit port (`if_commit`/`pos_commit`/`data_commit`/`tag_commit`). On retiring a mispredicted branch it drives the pipeline-wide `clear` and the redirect PC.

## Interface
- `DEPTH`, 16: entry count; power of two.
- `TAG_W`, 5: tag width. Tags `0..DEPTH-1` are entry indices; `DEPTH` (5'd16) is the empty tag.
- `clk` input 1: single clock, all state on rising edge.
- `rst` input 1: reset, synchronous and active-low (0 = reset).
- `rdy` input 1: global enable; 0 freezes all state and registered outputs.
- `dispatch_valid` input 1: decoder allocates one entry this cycle.
- `dispatch_rd` input 5: destination register; 0 means no writeback.
- `dispatch_is_branch` input 1: entry is a branch/jump.
- `dispatch_tag` output TAG_W: tag the next allocation receives (= tail index).
- `full` output 1: `count == DEPTH`; dispatch ignored while high.
- `query_tag1`, `query_tag2` input TAG_W: operand tags from the regfile lookup.
- `query_ready1`, `query_ready2` output 1: the queried entry holds its result.
- `query_data1`, `query_data2` output 32: the result value.
- `cdb_valid` input 1: result broadcast.
- `cdb_tag` input TAG_W: producing entry.
- `cdb_data` input 32: result value.
- `cdb_mispredict` input 1: the branch resolved against its prediction.
- `cdb_target_pc` input 32: correct PC for a mispredicted branch.
- `if_commit` output 1: one-cycle retire pulse to the regfile.
- `pos_commit` output 5: destination register.
- `data_commit` output 32: value.
- `tag_commit` output TAG_W: retiring entry's tag.
- `clear` output 1: one-cycle flush pulse to all stages.
- `clear_pc` output 32: fetch redirect target, valid while `clear` is high.

## Operation
- Per-entry state: `busy`, `ready`, `rd[4:0]`, `data[31:0]`, `is_branch`, `mispredict`, `target_pc[31:0]`. Pointers `head`, `tail` are 4-bit and wrap modulo DEPTH. `count` is 0..DEPTH.
- Dispatch: when `dispatch_valid && !full && !clear`, entry `tail` gets `busy=1`, `ready=0` and the `rd`/`is_branch` fields; `tail` increments.
- CDB write: when `cdb_valid && cdb_tag != DEPTH && busy[cdb_tag]`, the entry gets `ready=1`, `data=cdb_data`, `mispredict=cdb_mispredict`, `target_pc=cdb_target_pc`. A CDB write to a non-busy entry is ignored.
- Retire: when `busy[head] && ready[head]`, the entry frees and `head` increments. At most one retire per cycle.
  - Non-mispredicted entry with `rd != 0`: registered outputs `if_commit=1`, `pos_commit=rd`, `data_commit=data`, `tag_commit=head` for the next cycle.
  - Entry with `rd == 0` (including a correctly predicted branch): retires silently, `if_commit=0`.
- Mispredicted branch retire: `if_commit` pulses with `rd` if `rd != 0` (JAL/JALR link), in the same cycle as `clear`. All entries get `busy=0`, `head=tail=0`, `count=0`, and registered `clear=1`, `clear_pc=target_pc` for one cycle.
- `count` update: +1 on dispatch, -1 on retire, unchanged when both happen. Flush overrides both to 0.
- Queries are combinational. For tag `t != DEPTH`:
  - `ready = ready[t] || (cdb_valid && cdb_tag == t)`.
  - `data` selects the CDB value on a same-cycle match, else `data[t]`.
  - `t == DEPTH`: ready=0, data=0.

## Timing
- Reset (rst=0 at an edge): all entries not busy, pointers/count 0. `if_commit=0`, `pos_commit=0`, `data_commit=0`, `tag_commit=DEPTH`, `clear=0`, `clear_pc=0`. `full=0`, `dispatch_tag=0`. Reset mid-operation discards all entries; reset wins over `rdy`.
- CDB to retire: an entry written at edge N retires at edge N+1 if it is head. `if_commit` is high during cycle N+1..N+2 (one cycle).
- `if_commit`, `clear` and `clear_pc` are single-cycle pulses; they return to 0 the following cycle unless a new retire occurs.
- While `clear` is high, dispatch and CDB inputs are ignored.
- `full` is derived from registered `count`. With `count == DEPTH`, a same-cycle retire does not admit a dispatch.
- `rdy=0`: no pointer, entry or output register changes.

## Test plan
- Reset then dispatch rd=5 (tag 0), CDB tag0 data 0x1234 -> `if_commit=1`, pos 5, data 0x1234, tag 0 exactly 2 edges after CDB write, then 0.
- Dispatch 16 entries -> `full=1`, 17th ignored, `dispatch_tag` wraps to 0. CDB the entries out of order 15..0 -> commits emerge in order 0..15, one per cycle.
- CDB tag 3 data 0xAB while querying tag 3 in the same cycle -> `query_ready=1`, `query_data=0xAB` via bypass. Query tag 16 -> ready 0.
- Branch at head with `cdb_mispredict=1`, target 0x100, and 3 younger entries -> `clear=1` for one cycle with `clear_pc=0x100`, `full=0`, next `dispatch_tag=0`, younger results never commit.
- Mid-stream rst=0 with 5 busy entries -> all outputs at their reset values next cycle. `rdy=0` for 3 cycles with a ready head -> no commit until `rdy` returns.
